// File: rtl/gb_vram_pkg.sv
// Shared VRAM arbiter defaults and requester port numbering.
// Pure declarations: no logic, no latency, no flow control.
package gb_vram_pkg;

    localparam int NREQ_DEF   = 8;
    localparam int AW_DEF     = 13;
    localparam int DW_DEF     = 8;
    localparam int RD_LAT_DEF = 1;

    // Requester slots; indices 6 and 7 are spare.
    typedef enum logic [2:0] {
        PORT_FETCH_A    = 3'd0,
        PORT_FETCH_B_LO = 3'd1,
        PORT_FETCH_B_HI = 3'd2,
        PORT_FETCH_C_LO = 3'd3,
        PORT_FETCH_C_HI = 3'd4,
        PORT_CPU_RD     = 3'd5
    } vram_port_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first requester at or above ptr, ascending modulo NREQ.
// Purely combinational; no state and no backpressure of its own.
module rr_select
    import gb_vram_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = (int'(ptr) + i) % NREQ;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: CPU writes always win, reads are round-robin, one access per cycle.
// Grants are combinational; data returns RD_LAT cycles later; requesters stall by holding rd_req.
module vram_port_arbiter
    import gb_vram_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [NREQ-1:0]      rd_req,
    input  logic [NREQ*AW-1:0]   rd_addr,
    output logic [NREQ-1:0]      rd_gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy
);

    localparam int PW = ptr_width(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] sel_gnt;
    logic [PW-1:0]   sel_idx;
    logic            rd_go;
    logic [AW-1:0]   port_addr [NREQ];

    // Return pipeline: stage 0 holds this cycle's grant, the last stage lines up with mem_rdata.
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [PW-1:0]     id_q [RD_LAT];
    logic [PW-1:0]     id_d [RD_LAT];

    for (genvar i = 0; i < NREQ; i++) begin : g_addr
        assign port_addr[i] = rd_addr[i*AW +: AW];
    end

    rr_select #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_select (
        .req (rd_req),
        .ptr (ptr_q),
        .gnt (sel_gnt),
        .idx (sel_idx)
    );

    assign rd_go = !rst && !wr_en && (|rd_req);

    always_comb begin
        ptr_d = ptr_q;
        if (rd_go) begin
            ptr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_go;
        id_d[0]  = sel_idx;
        for (int s = 1; s < RD_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            vld_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
        end
    end

    // Port ids are only meaningful alongside their valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        id_q <= id_d;
    end

    always_comb begin
        rd_gnt    = rd_go ? sel_gnt : '0;
        mem_en    = !rst && (wr_en || (|rd_req));
        mem_we    = !rst && wr_en;
        mem_addr  = wr_en ? wr_addr : port_addr[sel_idx];
        mem_wdata = wr_data;
        rd_valid  = '0;
        if (!rst && vld_q[RD_LAT-1]) begin
            rd_valid = NREQ'(1) << id_q[RD_LAT-1];
        end
        rd_data   = mem_rdata;
        busy      = !rst && ((|rd_req) || (|vld_q));
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: RD_LAT=1 and RD_LAT=2 instances share stimulus,
// each backed by its own behavioural VRAM; a reference memory and grant model drive a return scoreboard.
module tb_vram_port_arbiter;
    import gb_vram_pkg::*;

    localparam int NREQ = 8;
    localparam int AW   = 13;
    localparam int DW   = 8;

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [NREQ-1:0]     rd_req;
    logic [NREQ*AW-1:0]  rd_addr;

    logic [NREQ-1:0] gnt    [2];
    logic [NREQ-1:0] vld    [2];
    logic [DW-1:0]   rdat   [2];
    logic            men    [2];
    logic            mwe    [2];
    logic [AW-1:0]   maddr  [2];
    logic [DW-1:0]   mwdata [2];
    logic [DW-1:0]   mrdata [2];
    logic            busy   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mptr   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [DW-1:0]   ref_mem [1<<AW];
    logic [DW-1:0]   vram    [2][1<<AW];
    logic [NREQ-1:0] last_eg = '0;
    int              waits   [NREQ];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == AW'(16)) return 8'hA5;
        return a[7:0] ^ {a[12:8], a[2:0]};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(1, 0) == 1) return AW'($urandom_range(15, 0));
        return AW'($urandom);
    endfunction

    vram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(gnt[0]), .rd_valid(vld[0]),
        .rd_data(rdat[0]), .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]), .busy(busy[0])
    );

    vram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(gnt[1]), .rd_valid(vld[1]),
        .rd_data(rdat[1]), .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]), .busy(busy[1])
    );

    // Behavioural VRAMs: requests captured mid-cycle, applied on the rising edge.
    initial begin : vram_model
        logic          c_en [2];
        logic          c_we [2];
        logic [AW-1:0] c_ad [2];
        logic [DW-1:0] c_wd [2];
        logic [DW-1:0] stage2;
        for (int a = 0; a < (1 << AW); a++) begin
            vram[0][a] = init_val(AW'(a));
            vram[1][a] = init_val(AW'(a));
        end
        mrdata[0] = '0;
        mrdata[1] = '0;
        stage2    = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                c_en[d] = men[d];
                c_we[d] = mwe[d];
                c_ad[d] = maddr[d];
                c_wd[d] = mwdata[d];
            end
            @(posedge clk);
            mrdata[1] = stage2;
            for (int d = 0; d < 2; d++) begin
                if (c_en[d] === 1'b1) begin
                    if (c_we[d] === 1'b1) vram[d][c_ad[d]] = c_wd[d];
                    else if (d == 0)      mrdata[0] = vram[0][c_ad[d]];
                    else                  stage2    = vram[1][c_ad[d]];
                end
            end
        end
    end

    // Reference model: expected grant, memory controls, busy, returns and per-port wait bound.
    initial begin : monitor
        int              eidx;
        int              p;
        logic [NREQ-1:0] eg;
        logic [AW-1:0]   ea;
        exp_t            e;
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_val(AW'(a));
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (gnt[d] !== '0 || vld[d] !== '0 || men[d] !== 1'b0 || mwe[d] !== 1'b0 || busy[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_outputs dut%0d cyc=%0d: gnt=%h vld=%h en=%b we=%b busy=%b, required all zero",
                                 d, cyc, gnt[d], vld[d], men[d], mwe[d], busy[d]);
                    end
                end
                q0.delete();
                q1.delete();
                mptr    = 0;
                last_eg = '0;
                for (int i = 0; i < NREQ; i++) waits[i] = 0;
            end else begin
                eidx = -1;
                if (!wr_en) begin
                    for (int k = 0; k < NREQ; k++) begin
                        p = (mptr + k) % NREQ;
                        if (eidx < 0 && rd_req[p]) eidx = p;
                    end
                end
                eg = (eidx >= 0) ? (NREQ'(1) << eidx) : '0;
                ea = (eidx >= 0) ? rd_addr[eidx*AW +: AW] : '0;
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (gnt[d] !== eg) begin
                        errors++;
                        $display("FAIL grant dut%0d cyc=%0d: got %h, required %h", d, cyc, gnt[d], eg);
                    end
                    checks++;
                    if (men[d] !== (wr_en || rd_req != '0) || mwe[d] !== wr_en) begin
                        errors++;
                        $display("FAIL mem_ctl dut%0d cyc=%0d: en=%b we=%b, required en=%b we=%b",
                                 d, cyc, men[d], mwe[d], (wr_en || rd_req != '0), wr_en);
                    end
                    if (wr_en) begin
                        checks++;
                        if (maddr[d] !== wr_addr || mwdata[d] !== wr_data) begin
                            errors++;
                            $display("FAIL mem_write dut%0d cyc=%0d: addr=%h data=%h, required %h %h",
                                     d, cyc, maddr[d], mwdata[d], wr_addr, wr_data);
                        end
                    end else if (eidx >= 0) begin
                        checks++;
                        if (maddr[d] !== ea) begin
                            errors++;
                            $display("FAIL mem_read_addr dut%0d cyc=%0d: got %h, required %h", d, cyc, maddr[d], ea);
                        end
                    end
                end
                checks++;
                if (busy[0] !== (rd_req != '0 || q0.size() > 0) || busy[1] !== (rd_req != '0 || q1.size() > 0)) begin
                    errors++;
                    $display("FAIL busy cyc=%0d: got %b/%b, required %b/%b", cyc, busy[0], busy[1],
                             (rd_req != '0 || q0.size() > 0), (rd_req != '0 || q1.size() > 0));
                end
                checks++;
                if (q0.size() > 0 && q0[0].due == cyc) begin
                    e = q0.pop_front();
                    if (vld[0] !== (NREQ'(1) << e.port) || rdat[0] !== e.data) begin
                        errors++;
                        $display("FAIL return_l1 cyc=%0d: vld=%h data=%h, required %h %h",
                                 cyc, vld[0], rdat[0], NREQ'(1) << e.port, e.data);
                    end
                end else if (vld[0] !== '0) begin
                    errors++;
                    $display("FAIL spurious_l1 cyc=%0d: vld=%h, required 0", cyc, vld[0]);
                end
                checks++;
                if (q1.size() > 0 && q1[0].due == cyc) begin
                    e = q1.pop_front();
                    if (vld[1] !== (NREQ'(1) << e.port) || rdat[1] !== e.data) begin
                        errors++;
                        $display("FAIL return_l2 cyc=%0d: vld=%h data=%h, required %h %h",
                                 cyc, vld[1], rdat[1], NREQ'(1) << e.port, e.data);
                    end
                end else if (vld[1] !== '0) begin
                    errors++;
                    $display("FAIL spurious_l2 cyc=%0d: vld=%h, required 0", cyc, vld[1]);
                end
                if (eidx >= 0) begin
                    e.port = eidx;
                    e.data = ref_mem[ea];
                    e.due  = cyc + 1;
                    q0.push_back(e);
                    e.due  = cyc + 2;
                    q1.push_back(e);
                    mptr = (eidx + 1) % NREQ;
                end
                if (wr_en) ref_mem[wr_addr] = wr_data;
                last_eg = eg;
                for (int i = 0; i < NREQ; i++) begin
                    if (rd_req[i] && !gnt[0][i] && !wr_en) begin
                        waits[i]++;
                        checks++;
                        if (waits[i] > NREQ - 1) begin
                            errors++;
                            $display("FAIL starvation port%0d cyc=%0d: waited %0d, required <= %0d", i, cyc, waits[i], NREQ - 1);
                        end
                    end else if (!rd_req[i] || gnt[0][i]) begin
                        waits[i] = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic do_reset();
        tick();
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_req = '0;
        tick();
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        rd_req = '1;
        wr_en  = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt[0] !== '0 || vld[0] !== '0 || men[0] !== 1'b0 || mwe[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL test_reset: gnt=%h vld=%h en=%b we=%b busy=%b, required all zero",
                     gnt[0], vld[0], men[0], mwe[0], busy[0]);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        rd_req = 8'h01;
        set_addr(0, AW'(16));
        @(negedge clk);
        checks++;
        if (gnt[0] !== 8'h01 || maddr[0] !== AW'(16) || men[0] !== 1'b1 || mwe[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: gnt=%h addr=%h en=%b we=%b, required 01 0010 1 0", gnt[0], maddr[0], men[0], mwe[0]);
        end
        tick();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (vld[0] !== 8'h01 || rdat[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_return: vld=%h data=%h, required 01 a5", vld[0], rdat[0]);
        end
    endtask

    task automatic test_rr_sweep();
        do_reset();
        for (int p = 0; p < NREQ; p++) set_addr(p, AW'(p * 257));
        rd_req = '1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            checks++;
            if (gnt[0] !== (NREQ'(1) << (k % NREQ))) begin
                errors++;
                $display("FAIL rr_grant k=%0d: got %h, required %h", k, gnt[0], NREQ'(1) << (k % NREQ));
            end
            if (k > 0) begin
                checks++;
                if (vld[0] !== (NREQ'(1) << ((k - 1) % NREQ))) begin
                    errors++;
                    $display("FAIL rr_valid k=%0d: got %h, required %h", k, vld[0], NREQ'(1) << ((k - 1) % NREQ));
                end
            end
        end
        tick();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (vld[0] !== 8'h02) begin
            errors++;
            $display("FAIL rr_last_valid: got %h, required 02", vld[0]);
        end
    endtask

    task automatic test_write_priority();
        do_reset();
        rd_req  = 8'h04;
        set_addr(2, 13'h1234);
        wr_en   = 1'b1;
        wr_addr = 13'h1234;
        wr_data = 8'h55;
        @(negedge clk);
        checks++;
        if (gnt[0] !== '0 || mwe[0] !== 1'b1 || men[0] !== 1'b1 || maddr[0] !== 13'h1234 || mwdata[0] !== 8'h55) begin
            errors++;
            $display("FAIL write_cycle: gnt=%h we=%b en=%b addr=%h wd=%h, required 00 1 1 1234 55",
                     gnt[0], mwe[0], men[0], maddr[0], mwdata[0]);
        end
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt[0] !== 8'h04 || mwe[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_then_grant: gnt=%h we=%b, required 04 0", gnt[0], mwe[0]);
        end
        tick();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (vld[0] !== 8'h04 || rdat[0] !== 8'h55) begin
            errors++;
            $display("FAIL write_readback: vld=%h data=%h, required 04 55", vld[0], rdat[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (men[0] !== 1'b0 || mwe[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle: en=%b we=%b busy=%b, required 0 0 0", men[0], mwe[0], busy[0]);
        end
    endtask

    task automatic test_lat2();
        do_reset();
        set_addr(3, AW'(12'h333));
        set_addr(5, AW'(12'h555));
        rd_req = 8'h28;
        @(negedge clk);
        checks++;
        if (gnt[1] !== 8'h08) begin
            errors++;
            $display("FAIL lat2_first_grant: got %h, required 08", gnt[1]);
        end
        tick();
        rd_req = 8'h20;
        @(negedge clk);
        checks++;
        if (gnt[1] !== 8'h20 || vld[1] !== '0) begin
            errors++;
            $display("FAIL lat2_second_grant: gnt=%h vld=%h, required 20 00", gnt[1], vld[1]);
        end
        tick();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (vld[1] !== 8'h08 || rdat[1] !== init_val(AW'(12'h333)) || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL lat2_return3: vld=%h data=%h busy=%b, required 08 %h 1", vld[1], rdat[1], busy[1], init_val(AW'(12'h333)));
        end
        tick();
        @(negedge clk);
        checks++;
        if (vld[1] !== 8'h20 || rdat[1] !== init_val(AW'(12'h555))) begin
            errors++;
            $display("FAIL lat2_return5: vld=%h data=%h, required 20 %h", vld[1], rdat[1], init_val(AW'(12'h555)));
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_addr(0, AW'(32));
        set_addr(1, AW'(33));
        set_addr(7, AW'(40));
        rd_req = 8'h03;
        tick();
        rd_req = 8'h02;
        tick();
        rd_req = '0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        rd_req = 8'h81;
        @(negedge clk);
        checks++;
        if (vld[0] !== '0 || vld[1] !== '0 || gnt[1] !== 8'h01) begin
            errors++;
            $display("FAIL rst_flight_first: vld=%h/%h gnt=%h, required 00/00 01", vld[0], vld[1], gnt[1]);
        end
        tick();
        rd_req = 8'h80;
        @(negedge clk);
        checks++;
        if (vld[1] !== '0 || vld[0] !== 8'h01 || gnt[1] !== 8'h80) begin
            errors++;
            $display("FAIL rst_flight_second: vld=%h/%h gnt=%h, required 01/00 80", vld[0], vld[1], gnt[1]);
        end
        tick();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (vld[1] !== 8'h01 || rdat[1] !== init_val(AW'(32))) begin
            errors++;
            $display("FAIL rst_flight_return: vld=%h data=%h, required 01 %h", vld[1], rdat[1], init_val(AW'(32)));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            for (int p = 0; p < NREQ; p++) begin
                if (rd_req[p] && last_eg[p]) begin
                    if ($urandom_range(1, 0) == 1) set_addr(p, rand_addr());
                    else rd_req[p] = 1'b0;
                end else if (rd_req[p]) begin
                    if ($urandom_range(31, 0) == 0) rd_req[p] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    rd_req[p] = 1'b1;
                    set_addr(p, rand_addr());
                end
            end
            wr_en   = ($urandom_range(4, 0) == 0);
            wr_addr = rand_addr();
            wr_data = DW'($urandom);
            tick();
        end
        rd_req = '0;
        wr_en  = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL random_drain: outstanding %0d/%0d, required 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = '0;
        rd_addr = '0;
        test_reset();
        test_single_read();
        test_rr_sweep();
        test_write_priority();
        test_lat2();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
